// File: rtl/cpu_pkg.sv
// Shared CPU constants.
//   ADDR_W        : architectural address width
//   RAS_OVF_WRAP  : return-address stack overwrites its oldest entry when full
//   RAS_OVF_DROP  : return-address stack ignores a push when full
package cpu_pkg;
  localparam int ADDR_W       = 32;
  localparam int RAS_OVF_WRAP = 0;
  localparam int RAS_OVF_DROP = 1;
endpackage

// File: rtl/ret_addr_stack.sv
// Return-address stack for jal/jr prediction.
// Circular array of DEPTH entries addressed by a wrapping top pointer, plus
// a saturating occupancy count. The top entry is presented combinationally.
// Overflow, underflow and mispredict are registered one-cycle pulses.
//
// Ports
//   clk, rst     : clock, synchronous active-high reset
//   push         : jal retiring, save push_addr
//   push_addr    : return address (pc+4)
//   pop          : jr retiring, consume top entry
//   pop_actual   : real jr target, compared against the popped top entry
//   flush        : discard all entries (wins over push/pop)
//   top_addr     : current top entry, 0 when empty
//   top_valid    : stack non-empty
//   count        : number of valid entries
//   overflow     : pulse, push into a full stack
//   underflow    : pulse, pop from an empty stack
//   mispredict   : pulse, popped top differed from pop_actual
module ret_addr_stack
  import cpu_pkg::*;
#(
  parameter int AW       = ADDR_W,
  parameter int DEPTH    = 8,
  parameter int OVF_MODE = RAS_OVF_WRAP
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [AW-1:0]              push_addr,
  input  logic                       pop,
  input  logic [AW-1:0]              pop_actual,
  input  logic                       flush,
  output logic [AW-1:0]              top_addr,
  output logic                       top_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       mispredict
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [AW-1:0] mem_q [DEPTH];
  logic [PW-1:0] ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          mis_q, mis_d;
  logic          wr_en;
  logic [PW-1:0] wr_idx;
  logic          empty, full;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CW'(DEPTH));

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    ovf_d  = 1'b0;
    unf_d  = 1'b0;
    mis_d  = 1'b0;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (flush) begin
      cnt_d = '0;
      ptr_d = '0;
    end else begin
      // pop is always judged against the pre-update top
      if (pop && empty)  unf_d = 1'b1;
      if (pop && !empty) mis_d = (pop_actual != mem_q[ptr_q]);

      if (push && pop && !empty) begin
        // replace top in place; occupancy unchanged (no overflow even if full)
        wr_en  = 1'b1;
        wr_idx = ptr_q;
      end else if (push) begin
        if (full) begin
          ovf_d = 1'b1;
          // wrap mode: the slot after top is the oldest entry, reuse it
          if (OVF_MODE == RAS_OVF_WRAP) begin
            ptr_d  = ptr_q + PW'(1);
            wr_en  = 1'b1;
            wr_idx = ptr_q + PW'(1);
          end
        end else begin
          ptr_d  = ptr_q + PW'(1);
          cnt_d  = cnt_q + CW'(1);
          wr_en  = 1'b1;
          wr_idx = ptr_q + PW'(1);
        end
      end else if (pop && !empty) begin
        ptr_d = ptr_q - PW'(1);
        cnt_d = cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
      mis_q <= mis_d;
    end
  end

  // Entry storage carries no reset; validity comes from the count.
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem_q[wr_idx] <= push_addr;
  end

  assign top_valid  = !empty;
  assign top_addr   = empty ? '0 : mem_q[ptr_q];
  assign count      = cnt_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign mispredict = mis_q;

endmodule

// File: tb/tb_ret_addr_stack.sv
// Bench for ret_addr_stack: a wrap-mode and a drop-mode instance (DEPTH=4)
// share all inputs and are compared every cycle against a list model.
module tb_ret_addr_stack;
  localparam int AW = 32;
  localparam int D  = 4;

  logic          clk = 1'b0;
  logic          rst, push, pop, flush;
  logic [AW-1:0] push_addr, pop_actual;

  logic [AW-1:0] top_w, top_d;
  logic          tv_w, tv_d, ovf_w, ovf_d, unf_w, unf_d, mis_w, mis_d;
  logic [2:0]    cnt_w, cnt_d;

  ret_addr_stack #(.AW(AW), .DEPTH(D), .OVF_MODE(0)) u_wrap (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop),
    .pop_actual(pop_actual), .flush(flush), .top_addr(top_w), .top_valid(tv_w),
    .count(cnt_w), .overflow(ovf_w), .underflow(unf_w), .mispredict(mis_w));

  ret_addr_stack #(.AW(AW), .DEPTH(D), .OVF_MODE(1)) u_drop (
    .clk(clk), .rst(rst), .push(push), .push_addr(push_addr), .pop(pop),
    .pop_actual(pop_actual), .flush(flush), .top_addr(top_d), .top_valid(tv_d),
    .count(cnt_d), .overflow(ovf_d), .underflow(unf_d), .mispredict(mis_d));

  always #5 clk = ~clk;

  // Model: st[m][0] is the oldest entry, st[m][n[m]-1] the top.
  logic [31:0] st [2][D];
  int          n [2];
  bit          eo [2], eu [2], em [2];

  int checks = 0;
  int errs   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic model(input int m, input bit pu, input logic [31:0] pa,
                       input bit po, input logic [31:0] act, input bit fl, input bit rs);
    eo[m] = 0; eu[m] = 0; em[m] = 0;
    if (rs || fl) begin
      n[m] = 0;
    end else begin
      if (po && n[m] == 0) eu[m] = 1;
      if (po && n[m] > 0)  em[m] = (act != st[m][n[m]-1]);
      if (pu && po && n[m] > 0) begin
        st[m][n[m]-1] = pa;
      end else if (pu) begin
        if (n[m] < D) begin
          st[m][n[m]] = pa;
          n[m]++;
        end else begin
          eo[m] = 1;
          if (m == 0) begin
            for (int k = 0; k < D-1; k++) st[m][k] = st[m][k+1];
            st[m][D-1] = pa;
          end
        end
      end else if (po && n[m] > 0) begin
        n[m]--;
      end
    end
  endtask

  function automatic logic [31:0] mtop(input int m);
    return (n[m] > 0) ? st[m][n[m]-1] : 32'h0;
  endfunction

  task automatic step(input bit pu, input logic [31:0] pa, input bit po,
                      input logic [31:0] act, input bit fl, input bit rs);
    @(negedge clk);
    push = pu; push_addr = pa; pop = po; pop_actual = act; flush = fl; rst = rs;
    model(0, pu, pa, po, act, fl, rs);
    model(1, pu, pa, po, act, fl, rs);
    @(posedge clk);
    #1;
    chk("wrap.top",   top_w, mtop(0));
    chk("wrap.valid", tv_w,  n[0] > 0);
    chk("wrap.count", cnt_w, n[0]);
    chk("wrap.ovf",   ovf_w, eo[0]);
    chk("wrap.unf",   unf_w, eu[0]);
    chk("wrap.mis",   mis_w, em[0]);
    chk("drop.top",   top_d, mtop(1));
    chk("drop.valid", tv_d,  n[1] > 0);
    chk("drop.count", cnt_d, n[1]);
    chk("drop.ovf",   ovf_d, eo[1]);
    chk("drop.unf",   unf_d, eu[1]);
    chk("drop.mis",   mis_d, em[1]);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    rst = 1; push = 0; pop = 0; flush = 0; push_addr = 0; pop_actual = 0;
    n[0] = 0; n[1] = 0;
    do_reset();
    chk("reset.count", cnt_w, 0);
    chk("reset.top",   top_w, 0);

    // basic push/pop with correct prediction
    step(1, 32'h100, 0, 0, 0, 0);
    step(1, 32'h200, 0, 0, 0, 0);
    step(1, 32'h300, 0, 0, 0, 0);
    step(0, 0, 1, 32'h300, 0, 0);
    chk("basic.top_const", top_w, 32'h200);
    chk("basic.cnt_const", cnt_w, 2);

    // underflow on empty
    do_reset();
    step(0, 0, 1, 32'h55, 0, 0);
    chk("unf.const", unf_w, 1);
    step(0, 0, 0, 0, 0, 0);

    // overflow: five pushes, then pops past empty
    do_reset();
    step(1, 32'h10, 0, 0, 0, 0);
    step(1, 32'h20, 0, 0, 0, 0);
    step(1, 32'h30, 0, 0, 0, 0);
    step(1, 32'h40, 0, 0, 0, 0);
    step(1, 32'h50, 0, 0, 0, 0);
    chk("ovf.wrap_top_const", top_w, 32'h50);
    chk("ovf.drop_top_const", top_d, 32'h40);
    chk("ovf.drop_cnt_const", cnt_d, 4);
    for (int i = 0; i < 5; i++) step(0, 0, 1, 32'h0, 0, 0);
    chk("ovf.wrap_empty_const", cnt_w, 0);

    // simultaneous push+pop with mispredict
    do_reset();
    step(1, 32'h100, 0, 0, 0, 0);
    step(1, 32'h200, 0, 0, 0, 0);
    step(1, 32'h400, 1, 32'h204, 0, 0);
    chk("pp.mis_const", mis_w, 1);
    chk("pp.top_const", top_w, 32'h400);
    step(0, 0, 0, 0, 0, 0);

    // simultaneous push+pop on empty: push plus underflow
    do_reset();
    step(1, 32'h900, 1, 32'h900, 0, 0);

    // flush beats push, reset mid-push
    do_reset();
    step(1, 32'h1, 0, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0, 0);
    step(1, 32'h3, 0, 0, 0, 0);
    step(1, 32'h4, 1, 32'h0, 1, 0);
    step(1, 32'h5, 0, 0, 0, 0);
    step(1, 32'h6, 1, 32'h0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 800; i++) begin
      bit          pu, po, fl, rs;
      logic [31:0] pa, act;
      pu  = ($urandom_range(0, 9) < 5);
      po  = ($urandom_range(0, 9) < 4);
      fl  = ($urandom_range(0, 29) == 0);
      rs  = ($urandom_range(0, 59) == 0);
      pa  = 32'($urandom_range(1, 63)) << 2;
      act = ($urandom_range(0, 1) == 1 && n[0] > 0) ? st[0][n[0]-1]
                                                     : 32'($urandom_range(1, 63)) << 2;
      step(pu, pa, po, act, fl, rs);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errs);
    $finish;
  end

endmodule

// File: doc/ret_addr_stack.md
RET_ADDR_STACK -- requirements
Module: ret_addr_stack

Interface
REQ-001 The block SHALL have parameter AW, default 32, meaning the return-address width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 8, meaning the number of entries (power of two, 2..64).
REQ-003 The block SHALL have parameter OVF_MODE, default 0, meaning full-stack push policy: 0 = wrap and overwrite the oldest entry, 1 = drop the push.
REQ-004 The block SHALL use one clock and a synchronous, active-high reset; clk and rst SHALL be the first two ports.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 push  in  1  jal retiring this cycle (ct_jal qualified).
REQ-008 push_addr  in  AW  return address to save (pc+4).
REQ-009 pop  in  1  jr retiring this cycle (ct_jr qualified).
REQ-010 pop_actual  in  AW  real jr target (rf_data_r1), used for the prediction check.
REQ-011 flush  in  1  discard all entries.
REQ-012 top_addr  out  AW  current top entry; 0 when empty.
REQ-013 top_valid  out  1  stack non-empty.
REQ-014 count  out  $clog2(DEPTH+1)  number of valid entries.
REQ-015 overflow  out  1  one-cycle pulse on a push into a full stack.
REQ-016 underflow  out  1  one-cycle pulse on a pop from an empty stack.
REQ-017 mispredict  out  1  one-cycle pulse one cycle after a pop whose pop_actual differs from the popped top_addr.

Function
REQ-018 Storage SHALL be a circular array of DEPTH entries with a top pointer (wraps modulo DEPTH) and a saturating count (0..DEPTH).
REQ-019 top_addr and top_valid SHALL be derived combinationally from the registered state, with zero added latency.
REQ-020 A push alone SHALL advance the pointer, write push_addr, and increment count; the new value SHALL be visible on top_addr in the next cycle.
REQ-021 A pop alone with count>0 SHALL retreat the pointer and decrement count.
REQ-022 A pop alone with count=0 SHALL leave state unchanged, pulse underflow, and SHALL NOT pulse mispredict.
REQ-023 Simultaneous push and pop SHALL evaluate the pop against the current top, then overwrite the top entry with push_addr; count SHALL be unchanged; on an empty stack this SHALL be push-only plus an underflow pulse.
REQ-024 A push when count=DEPTH with OVF_MODE=0 SHALL overwrite the oldest slot and advance the pointer, keep count at DEPTH, and pulse overflow.
REQ-025 A push when count=DEPTH with OVF_MODE=1 SHALL leave state unchanged and pulse overflow.
REQ-026 flush SHALL set count to 0 and override push and pop in the same cycle; no pulses SHALL be generated in that cycle.
REQ-027 mispredict SHALL be registered: it SHALL be asserted in cycle N+1 iff a pop in cycle N had top_valid=1 and pop_actual != top_addr.
REQ-028 overflow and underflow SHALL be registered pulses in cycle N+1 for an event in cycle N.

Reset
REQ-029 While rst=1 at a clk edge, the pointer, count, overflow, underflow and mispredict SHALL be cleared; top_valid=0 and top_addr=0 SHALL follow.
REQ-030 Entry contents need not be cleared.
REQ-031 A reset mid-sequence SHALL discard all entries and any pending pulse; a push or pop in the reset cycle SHALL be ignored.

Structure
REQ-032 The shared package cpu_pkg SHALL hold ADDR_W=32 and the constants RAS_OVF_WRAP=0 and RAS_OVF_DROP=1.
REQ-033 The block SHALL be a single module with no sub-module; pointer and count logic SHALL be inline.

Verification (DEPTH=4, AW=32)
REQ-034 Push 0x100, 0x200, 0x300, then pop with pop_actual=0x300 -> count 3,2; top_addr 0x200 after the pop; no mispredict.
REQ-035 Pop on an empty stack -> underflow=1 for one cycle; count 0; mispredict 0.
REQ-036 OVF_MODE=0: push 0x10, 0x20, 0x30, 0x40, 0x50; then pop four times -> overflow pulse on the fifth push; tops read 0x50, 0x40, 0x30, 0x20; count reaches 0 (0x10 is lost).
REQ-037 OVF_MODE=1: same push sequence -> overflow pulse; top stays 0x40; count 4.
REQ-038 With top 0x200 and count 2, drive push=pop=1, push_addr=0x400, pop_actual=0x204 -> mispredict pulse next cycle; top 0x400; count 2.
REQ-039 With count 3, drive flush and push together, then assert rst mid-push -> count 0 after flush; count 0, top_valid 0, no pulses after rst.
